// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: lit-high glyph table for hex digits 0..F,
// the all-dark pattern, and a width helper for counters and indices.
package seg7_pkg;

  // Lit-high segment patterns {g,f,e,d,c,b,a}, indexed by nibble value.
  localparam logic [15:0][6:0] SEG7_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // All segments dark, lit-high form.
  localparam logic [6:0] SEG7_OFF = 7'h00;

  // Bits needed to hold 0..n-1, never less than 1.
  function automatic int clog2(input int n);
    for (int r = 1; r < 32; r++) begin
      if ((32'd1 << r) >= n) return r;
    end
    return 32;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-glyph decoder producing lit-high segments.
// A blanked digit decodes to all segments dark.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg_lit
);

  // Table lookup, overridden to dark when the digit is blanked.
  always_comb begin
    seg_lit = SEG7_OFF;
    if (blank) begin
      seg_lit = SEG7_OFF;
    end else begin
      seg_lit = SEG7_HEX[nibble];
    end
  end

endmodule

// File: rtl/hex_scan_display.sv
// Time-multiplexed driver for DIGITS seven-segment hex digits on one shared
// segment bus. New values are captured into a shadow register and only
// committed to the display at a frame wrap, so a frame never mixes old and
// new digits. Anode enables are dark for the first cycle of every digit slot
// to suppress ghosting while the segment bus changes.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank digits above the most
// significant non-zero nibble of the committed value; digit 0 always shown).
module hex_scan_display
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  seg_dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done,
  output logic                  pending
);

  localparam int IW = clog2(DIGITS);
  localparam int CW = clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [6:0] SEG_OFF_LVL = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic DP_OFF_LVL = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [DIGITS-1:0] AN_OFF_LVL =
    (AN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [CW-1:0]          count;
  logic [IW-1:0]          idx;
  logic                   tick;
  logic                   wrap;
  logic [4*DIGITS-1:0]    shadow_value;
  logic [DIGITS-1:0]      shadow_dp;
  logic [DIGITS-1:0]      shadow_blank;
  logic [4*DIGITS-1:0]    disp_value;
  logic [DIGITS-1:0]      disp_dp;
  logic [DIGITS-1:0]      disp_blank;
  logic [3:0]             cur_nibble;
  logic                   cur_dp;
  logic                   cur_blank;
  logic                   auto_blank;
  logic                   dp_lit;
  logic [6:0]             cur_lit;
  logic [DIGITS-1:0]      cur_onehot;

  assign tick       = (count == CNT_LAST);
  assign wrap       = tick && (idx == IDX_LAST);
  assign frame_done = wrap;

  // Prescaler: counts clk cycles within one digit slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Digit index advances round-robin at the end of each slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (tick) begin
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      idx <= idx;
    end
  end

  // Shadow capture on load; commit to display at frame wrap. A load landing
  // on the wrap cycle bypasses the shadow and is committed directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_value <= '0;
      shadow_dp    <= '0;
      shadow_blank <= '0;
      disp_value   <= '0;
      disp_dp      <= '0;
      disp_blank   <= '0;
      pending      <= 1'b0;
    end else begin
      if (load) begin
        shadow_value <= value;
        shadow_dp    <= dp;
        shadow_blank <= blank;
      end
      if (wrap) begin
        disp_value <= load ? value : shadow_value;
        disp_dp    <= load ? dp    : shadow_dp;
        disp_blank <= load ? blank : shadow_blank;
        pending    <= 1'b0;
      end else if (load) begin
        pending    <= 1'b1;
      end else begin
        pending    <= pending;
      end
    end
  end

  // Select the committed nibble and flags for the digit currently scanned.
  always_comb begin
    cur_nibble = disp_value[4*int'(idx) +: 4];
    cur_dp     = disp_dp[idx];
    cur_blank  = disp_blank[idx];
    cur_onehot = DIGITS'(1) << idx;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] msd;

  // Locate the most significant non-zero digit; higher digits go dark.
  always_comb begin
    msd = '0;
    for (int i = 1; i < DIGITS; i++) begin
      if (disp_value[4*i +: 4] != 4'h0) begin
        msd = IW'(i);
      end else begin
        msd = msd;
      end
    end
    auto_blank = (idx > msd);
  end
`else
  assign auto_blank = 1'b0;
`endif

  // Explicit blank kills the dp too; auto-blanking leaves the dp alone.
  assign dp_lit = cur_dp & ~cur_blank;

  seg7_decode u_decode (
    .nibble  (cur_nibble),
    .blank   (cur_blank | auto_blank),
    .seg_lit (cur_lit)
  );

  // Output stage: polarity applied here, anodes held dark on slot entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg    <= SEG_OFF_LVL;
      seg_dp <= DP_OFF_LVL;
      an     <= AN_OFF_LVL;
    end else begin
      seg    <= (SEG_ACTIVE_LOW != 0) ? ~cur_lit : cur_lit;
      seg_dp <= (SEG_ACTIVE_LOW != 0) ? ~dp_lit : dp_lit;
      if (count == '0) begin
        an <= AN_OFF_LVL;
      end else begin
        an <= (AN_ACTIVE_LOW != 0) ? ~cur_onehot : cur_onehot;
      end
    end
  end

endmodule

// File: tb/tb_hex_scan_display.sv
// Self-checking bench for hex_scan_display (DIGITS=4, SCAN_DIV=4, active-low).
// A cycle-count based reference model predicts every output each clock;
// table vectors and hand sequences add fixed expectations on top.
module tb_hex_scan_display;

  localparam int DG = 4;
  localparam int SD = 4;
  localparam int FR = DG * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        load;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [3:0]  an;
  logic        frame_done;
  logic        pending;

  hex_scan_display #(
    .DIGITS(DG), .SCAN_DIV(SD), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .value(value), .dp(dp), .blank(blank), .load(load),
    .seg(seg), .seg_dp(seg_dp), .an(an), .frame_done(frame_done), .pending(pending)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] HEX_LIT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int pass_cnt = 0;
  int total_cnt = 0;

  // Reference model state: edges since reset, committed and shadow contents.
  int          n;
  logic [15:0] m_val, m_sval;
  logic [3:0]  m_dp, m_sdp, m_blk, m_sblk;
  logic        m_pend;

  typedef struct {
    logic [15:0]     v;
    logic [3:0]      d;
    logic [3:0]      b;
    logic [3:0][6:0] es;
    logic [3:0]      edp;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [6:0] digit_seg(input logic [15:0] v, input logic [3:0] b, input int d);
`ifdef LEADING_ZERO_BLANK_EN
    int top;
    top = 0;
    for (int k = 1; k < DG; k++) if (v[4*k +: 4] != 4'h0) top = k;
    if (d > top) return 7'h7F;
`endif
    if (b[d]) return 7'h7F;
    return ~HEX_LIT[v[4*d +: 4]];
  endfunction

  task automatic model_reset();
    n = 0;
    m_val = 16'h0; m_sval = 16'h0;
    m_dp = 4'h0; m_sdp = 4'h0; m_blk = 4'h0; m_sblk = 4'h0;
    m_pend = 1'b0;
  endtask

  // One clock: predict from the pre-edge state, advance model, compare.
  task automatic cyc();
    int c, i;
    logic [6:0] es;
    logic edp;
    logic [3:0] ean;
    c = n % SD;
    i = (n / SD) % DG;
    ean = (c == 0) ? 4'hF : ~(4'b0001 << i);
    es  = digit_seg(m_val, m_blk, i);
    edp = m_blk[i] ? 1'b1 : ~m_dp[i];
    if ((n % FR) == FR - 1) begin
      if (load) begin m_val = value; m_dp = dp; m_blk = blank; end
      else begin m_val = m_sval; m_dp = m_sdp; m_blk = m_sblk; end
      m_pend = 1'b0;
    end else if (load) begin
      m_pend = 1'b1;
    end
    if (load) begin m_sval = value; m_sdp = dp; m_sblk = blank; end
    n++;
    @(posedge clk); #1;
    check("model_seg", seg, es);
    check("model_dp", seg_dp, edp);
    check("model_an", an, ean);
    check("model_frame_done", frame_done, ((n % FR) == FR - 1));
    check("model_pending", pending, m_pend);
  endtask

  task automatic do_reset();
    rst = 1'b1; load = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    rst = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v; dp = d; blank = b; load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic wait_slot(input int s);
    int g = 0;
    while ((((n / SD) % DG) != s || (n % SD) != 0) && g < 40) begin cyc(); g++; end
  endtask

  // Wait for the wrap pulse with pending held, then clock through the commit.
  task automatic wait_wrap(input logic want_pending);
    int g = 0;
    while (!frame_done && g < 40) begin
      if (want_pending) check("pending_hold", pending, 1);
      cyc(); g++;
    end
    check("wrap_timeout", (g < 40), 1);
    cyc();
    check("pending_after_commit", pending, 0);
  endtask

  // Watch one frame; check each digit against fixed expectations.
  task automatic watch_frame(input string name, input logic [3:0][6:0] es, input logic [3:0] edp);
    for (int k = 0; k < FR + 1; k++) begin
      cyc();
      for (int d = 0; d < DG; d++) begin
        if (an == ~(4'b0001 << d)) begin
          check({name, "_seg"}, seg, es[d]);
          check({name, "_dp"}, seg_dp, edp[d]);
        end
      end
    end
  endtask

  initial begin
    int g, gap;
    logic [6:0] lz;
    vecs[0] = '{16'h12AF, 4'b0000, 4'b0000, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1111};
    vecs[1] = '{16'h7000, 4'b0001, 4'b0100, {7'h78, 7'h7F, 7'h40, 7'h40}, 4'b1110};
    vecs[2] = '{16'h3456, 4'b1010, 4'b0000, {7'h30, 7'h19, 7'h12, 7'h02}, 4'b0101};
    vecs[3] = '{16'h89BE, 4'b0000, 4'b1001, {7'h7F, 7'h10, 7'h03, 7'h7F}, 4'b1111};
    vecs[4] = '{16'hC0D0, 4'b1111, 4'b0000, {7'h46, 7'h40, 7'h21, 7'h40}, 4'b0000};

    value = 16'h0; dp = 4'h0; blank = 4'h0; load = 1'b0; rst = 1'b1;
    do_reset();
    rst = 1'b1; #1;
    check("reset_seg", seg, 7'h7F);
    check("reset_an", an, 4'hF);
    check("reset_dp", seg_dp, 1);
    check("reset_frame_done", frame_done, 0);
    check("reset_pending", pending, 0);
    do_reset();

    // Release: guard cycle first, then digit 0 enabled.
    cyc();
    check("release_guard_an", an, 4'hF);
    check("release_seg0", seg, 7'h40);
    cyc();
    check("release_an0", an, 4'hE);

    // Table vectors, each loaded at idx=1.
    for (int t = 0; t < 5; t++) begin
      wait_slot(1);
      do_load(vecs[t].v, vecs[t].d, vecs[t].b);
      wait_wrap(1'b1);
      watch_frame("vec", vecs[t].es, vecs[t].edp);
    end

    // Two loads in one frame: last one wins.
    wait_slot(1);
    do_load(16'h1111, 4'h0, 4'h0);
    cyc();
    do_load(16'h2222, 4'h0, 4'h0);
    wait_wrap(1'b1);
    watch_frame("last_load_wins", {4{7'h24}}, 4'hF);

    // Load on the exact wrap cycle commits directly.
    g = 0;
    while (!frame_done && g < 40) begin cyc(); g++; end
    check("wrap_find_timeout", (g < 40), 1);
    value = 16'h00C0; dp = 4'h0; blank = 4'h0; load = 1'b1;
    cyc();
    load = 1'b0;
    check("wrap_load_pending", pending, 0);
`ifdef LEADING_ZERO_BLANK_EN
    watch_frame("wrap_load", {7'h7F, 7'h7F, 7'h46, 7'h40}, 4'hF);
`else
    watch_frame("wrap_load", {7'h40, 7'h40, 7'h46, 7'h40}, 4'hF);
`endif

    // frame_done period.
    g = 0;
    while (!frame_done && g < 40) begin cyc(); g++; end
    gap = 0;
    cyc(); gap++;
    while (!frame_done && gap < 40) begin cyc(); gap++; end
    check("frame_period", gap, FR);

    // Leading-zero handling of 0050.
    wait_slot(1);
    do_load(16'h0050, 4'h0, 4'h0);
    wait_wrap(1'b1);
`ifdef LEADING_ZERO_BLANK_EN
    lz = 7'h7F;
`else
    lz = 7'h40;
`endif
    watch_frame("lzb", {lz, lz, 7'h12, 7'h40}, 4'hF);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      value = 16'($urandom);
      dp    = 4'($urandom);
      blank = 4'($urandom);
      load  = ($urandom_range(0, 7) == 0);
      cyc();
    end
    load = 1'b0;

    // Reset mid-slot with a pending value.
    wait_slot(2);
    cyc();
    do_load(16'hABCD, 4'hF, 4'h0);
    check("pre_reset_pending", pending, 1);
    #3 rst = 1'b1;
    #1;
    check("midrst_seg", seg, 7'h7F);
    check("midrst_an", an, 4'hF);
    check("midrst_dp", seg_dp, 1);
    check("midrst_frame_done", frame_done, 0);
    check("midrst_pending", pending, 0);
    do_reset();
    for (int k = 0; k < 2 * FR; k++) cyc();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
